// File: rtl/hazard_scoreboard.sv
// Hazard unit: registered (A3, Tnew) scoreboard for E/M/W driving D stall, forwarding selects and HI/LO busy.
// Latency: stall, fwd_* and md_busy are combinational from registered state and D inputs (same cycle).
// Backpressure: stall freezes PC/D and bubbles E; M/W and the md counter advance regardless.
module hazard_scoreboard #(
    parameter int TW          = 3,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CW          = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    D_rs,
    input  logic [4:0]    D_rt,
    input  logic [TW-1:0] D_Tuse_rs,
    input  logic [TW-1:0] D_Tuse_rt,
    input  logic [4:0]    D_A3,
    input  logic [TW-1:0] D_Tnew,
    input  logic          D_md_start,
    input  logic          D_md_is_div,
    input  logic          D_md_use,
    output logic          stall,
    output logic [1:0]    fwd_rs,
    output logic [1:0]    fwd_rt,
    output logic          md_busy
);

    logic [4:0]    e_a3, m_a3, w_a3;
    logic [TW-1:0] e_tnew, m_tnew, w_tnew;
    logic          e_md, e_div;
    logic [CW-1:0] cnt;

    logic stall_rs, stall_rt, stall_md;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
        return (x == '0) ? '0 : x - 1'b1;
    endfunction

    function automatic logic data_stall(input logic [4:0] r, input logic [TW-1:0] tuse,
                                        input logic [4:0] ea3, input logic [TW-1:0] etn,
                                        input logic [4:0] ma3, input logic [TW-1:0] mtn);
        logic s;
        s = 1'b0;
        if (r != 5'd0) begin
            if (r == ea3 && tuse < etn) s = 1'b1;
            if (r == ma3 && tuse < mtn) s = 1'b1;
        end
        return s;
    endfunction

    // Youngest matching stage decides; if it is not ready yet, read the regfile and let stall cover it.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                           input logic [4:0] ea3, input logic [TW-1:0] etn,
                                           input logic [4:0] ma3, input logic [TW-1:0] mtn,
                                           input logic [4:0] wa3, input logic [TW-1:0] wtn);
        logic [1:0] f;
        f = 2'd0;
        if (r != 5'd0) begin
            if (r == ea3)      f = (etn == '0) ? 2'd1 : 2'd0;
            else if (r == ma3) f = (mtn == '0) ? 2'd2 : 2'd0;
            else if (r == wa3) f = (wtn == '0) ? 2'd3 : 2'd0;
        end
        return f;
    endfunction

    always_comb begin
        stall_rs = data_stall(D_rs, D_Tuse_rs, e_a3, e_tnew, m_a3, m_tnew);
        stall_rt = data_stall(D_rt, D_Tuse_rt, e_a3, e_tnew, m_a3, m_tnew);
        md_busy  = e_md | (cnt != '0);
        stall_md = D_md_use & md_busy;
        stall    = stall_rs | stall_rt | stall_md;
        fwd_rs   = fwd_sel(D_rs, e_a3, e_tnew, m_a3, m_tnew, w_a3, w_tnew);
        fwd_rt   = fwd_sel(D_rt, e_a3, e_tnew, m_a3, m_tnew, w_a3, w_tnew);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_a3   <= '0;
            e_tnew <= '0;
            e_md   <= 1'b0;
            e_div  <= 1'b0;
            m_a3   <= '0;
            m_tnew <= '0;
            w_a3   <= '0;
            w_tnew <= '0;
            cnt    <= '0;
        end else begin
            if (stall) begin
                e_a3   <= '0;
                e_tnew <= '0;
                e_md   <= 1'b0;
                e_div  <= 1'b0;
            end else begin
                e_a3   <= D_A3;
                e_tnew <= D_Tnew;
                e_md   <= D_md_start;
                e_div  <= D_md_is_div;
            end
            m_a3   <= e_a3;
            m_tnew <= sat_dec(e_tnew);
            w_a3   <= m_a3;
            w_tnew <= sat_dec(m_tnew);
            // Reload on leaving E takes priority, so an op issued as cnt reaches 0 chains without a gap.
            if (e_md)
                cnt <= e_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: inputs driven 1 time unit after posedge, outputs sampled mid-cycle.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, D_A3;
    logic [2:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
    logic       D_md_start, D_md_is_div, D_md_use;
    logic       stall, md_busy;
    logic [1:0] fwd_rs, fwd_rt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.TW(3), .MULT_CYCLES(5), .DIV_CYCLES(10), .CW(4)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .D_A3(D_A3), .D_Tnew(D_Tnew),
        .D_md_start(D_md_start), .D_md_is_div(D_md_is_div), .D_md_use(D_md_use),
        .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [2:0] urs, input logic [2:0] urt,
                         input logic [4:0] a3, input logic [2:0] tn,
                         input logic ms, input logic mdv, input logic mu);
        D_rs = rs; D_rt = rt; D_Tuse_rs = urs; D_Tuse_rt = urt;
        D_A3 = a3; D_Tnew = tn; D_md_start = ms; D_md_is_div = mdv; D_md_use = mu;
    endtask

    // Next cycle: wait for the edge, drive D, then let combinational outputs settle.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [2:0] urs, input logic [2:0] urt,
                         input logic [4:0] a3, input logic [2:0] tn,
                         input logic ms, input logic mdv, input logic mu);
        @(posedge clk);
        #1;
        set_d(rs, rt, urs, urt, a3, tn, ms, mdv, mu);
        #3;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(0, 0, 7, 7, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_fwd_rs", fwd_rs, 0);
        chk("rst_fwd_rt", fwd_rt, 0);
        chk("rst_busy", md_busy, 0);
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        chk("idle_stall", stall, 0);

        // Load-use: lw $1 Tnew=2, add using $1 at Tuse 1.
        issue(0, 0, 7, 7, 1, 2, 0, 0, 0);
        chk("lw_issue", stall, 0);
        issue(1, 0, 1, 7, 4, 1, 0, 0, 0);
        chk("lu_stall1", stall, 1);
        issue(1, 0, 1, 7, 4, 1, 0, 0, 0);
        chk("lu_stall2", stall, 0);
        chk("lu_fwd_m_notready", fwd_rs, 0);
        issue(1, 0, 1, 7, 0, 0, 0, 0, 0);
        chk("lu_fwd_w", fwd_rs, 3);
        chk("lu_w_nostall", stall, 0);
        idle(3);

        // ALU to branch on both rs and rt.
        issue(0, 0, 7, 7, 2, 1, 0, 0, 0);
        issue(2, 2, 0, 0, 0, 0, 0, 0, 0);
        chk("br_stall1", stall, 1);
        chk("br_fwd_wait", fwd_rs, 0);
        issue(2, 2, 0, 0, 0, 0, 0, 0, 0);
        chk("br_stall2", stall, 0);
        chk("br_fwd_rs", fwd_rs, 2);
        chk("br_fwd_rt", fwd_rt, 2);
        idle(3);

        // Two writers of $3, Tnew=1: youngest (E) not ready -> regfile select, no stall.
        issue(0, 0, 7, 7, 3, 1, 0, 0, 0);
        issue(0, 0, 7, 7, 3, 1, 0, 0, 0);
        chk("pri1_nostall", stall, 0);
        issue(3, 0, 1, 7, 0, 0, 0, 0, 0);
        chk("pri1_stall", stall, 0);
        chk("pri1_fwd", fwd_rs, 0);
        idle(3);

        // Two writers of $3, Tnew=0: E wins over M.
        issue(0, 0, 7, 7, 3, 0, 0, 0, 0);
        issue(0, 0, 7, 7, 3, 0, 0, 0, 0);
        issue(0, 3, 7, 1, 0, 0, 0, 0, 0);
        chk("pri0_stall", stall, 0);
        chk("pri0_fwd_rt", fwd_rt, 1);
        idle(3);

        // $0 never stalls or forwards.
        issue(0, 0, 7, 7, 0, 2, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("z_stall_e", stall, 0);
        chk("z_fwd_rs", fwd_rs, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("z_stall_m", stall, 0);
        chk("z_fwd_rt", fwd_rt, 0);
        idle(3);

        // div in cycle 0, mflo held in D; mult issued back-to-back in cycle 12.
        issue(0, 0, 7, 7, 0, 0, 1, 1, 1);
        chk("div_issue", stall, 0);
        chk("div_busy0", md_busy, 0);
        for (int c = 1; c <= 11; c++) begin
            issue(0, 0, 7, 7, 0, 0, 0, 0, 1);
            chk($sformatf("div_busy_c%0d", c), md_busy, 1);
            chk($sformatf("div_stall_c%0d", c), stall, 1);
        end
        issue(0, 0, 7, 7, 0, 0, 1, 0, 1);
        chk("div_done_busy", md_busy, 0);
        chk("mult_b2b_issue", stall, 0);
        for (int c = 13; c <= 19; c++) begin
            issue(0, 0, 7, 7, 0, 0, 0, 0, 1);
            chk($sformatf("mul_busy_c%0d", c), md_busy, (c <= 18) ? 1 : 0);
            chk($sformatf("mul_stall_c%0d", c), stall, (c <= 18) ? 1 : 0);
        end
        idle(3);

        // Reset in cycle 4 of a div, with a data-dependent entry also in flight.
        issue(0, 0, 7, 7, 5, 2, 1, 1, 1);
        for (int c = 1; c <= 3; c++) issue(0, 0, 7, 7, 0, 0, 0, 0, 1);
        chk("rdiv_busy_pre", md_busy, 1);
        @(posedge clk);
        #1;
        set_d(5, 0, 0, 7, 0, 0, 0, 0, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("rdiv_busy_rst", md_busy, 0);
        chk("rdiv_stall_rst", stall, 0);
        @(negedge clk);
        reset = 1'b1;
        issue(0, 0, 7, 7, 0, 0, 0, 0, 1);
        chk("mfhi_stall", stall, 0);
        chk("mfhi_busy", md_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
